mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// Shares one line-wide main-memory port between the instruction-fetch miss path (I stage) and
// the data-access miss path (DM stage) of the pipelined datapath. Grants one requester at a time,
// data over instruction, latches the request, runs the memory handshake and returns a one-cycle
// response. Watchdog counter flags hung memory transactions.
// PARAMETERS
// ADDRESS_SIZE  32   byte-address width of both requesters and memory
// LINE_SIZE     128  data width of one memory transfer, bits
// TIMEOUT       255  max cycles in BUSY without mem_ack before abort; >=2
// PORTS
// clk        in   1             clock, all state updates on rising edge
// reset      in   1             asynchronous, active-low; 0 clears all state immediately
// ic_req     in   1             instruction read request; level, held until ic_valid
// ic_addr    in   ADDRESS_SIZE  instruction line address; stable while ic_req=1
// ic_valid   out  1             one-cycle pulse: ic_rdata valid, request done
// ic_rdata   out  LINE_SIZE     instruction line read data
// dc_req     in   1             data request; level, held until dc_valid
// dc_we      in   1             1 = write line, 0 = read line; stable while dc_req=1
// dc_addr    in   ADDRESS_SIZE  data line address; stable while dc_req=1
// dc_wdata   in   LINE_SIZE     write line data; stable while dc_req=1
// dc_valid   out  1             one-cycle pulse: data request done (dc_rdata valid for reads)
// dc_rdata   out  LINE_SIZE     data line read data
// mem_req    out  1             memory request, held until mem_ack
// mem_we     out  1             memory write enable
// mem_addr   out  ADDRESS_SIZE  memory address
// mem_wdata  out  LINE_SIZE     memory write data
// mem_ack    in   1             memory done; ignored unless mem_req=1
// mem_rdata  in   LINE_SIZE     memory read data, valid with mem_ack
// mem_err    out  1             sticky: a transaction timed out; cleared only by reset
// BEHAVIOUR
// - All outputs registered. Reset (reset=0): state IDLE, every output 0, watchdog 0, mem_err 0;
//   takes effect asynchronously, so mem_req drops mid-transaction; abandoned request gets no valid.
// - FSM states: IDLE, BUSY_I, BUSY_D, RESP.
// - IDLE: dc_req=1 -> BUSY_D (dc_req wins if both); else ic_req=1 -> BUSY_I; else stay.
//   On the grant edge latch addr/we/wdata into mem_*; mem_req=1 from next cycle. mem_we=0 for BUSY_I.
// - BUSY_x: mem_req held, mem_* constant. Watchdog increments each BUSY cycle.
//   mem_ack=1 -> RESP; latch mem_rdata into x_rdata (dc_rdata unchanged on writes); mem_req=0.
//   Watchdog reaches TIMEOUT without ack -> RESP, x_rdata<=0, mem_err<=1, mem_req=0.
// - RESP: exactly one cycle; x_valid=1 for the granted requester only; watchdog cleared; -> IDLE.
//   x_rdata holds its value until the next response to that requester.
// - Requester drops x_req on the edge ending its valid cycle; IDLE samples req one cycle after RESP,
//   so no double grant. Request seen after RESP is a new transaction.
// - Min latency: req high in cycle 0 -> mem_req cycle 1 -> ack cycle 1 -> valid cycle 2.
//   Back-to-back: next grant sampled cycle 3, mem_req cycle 4.
// - Fixed data priority is starvation-free: a data miss stalls fetch upstream.
// - mem_ack in IDLE/RESP ignored; ack and timeout in same cycle -> ack wins, no error.
// TESTING
// - Async reset mid BUSY_D: mem_req=0 the same cycle; no dc_valid; mem_err=0; next req grants normally.
// - ic_req, addr 0x1000; mem_ack 3 cycles after mem_req -> mem_addr=0x1000, mem_we=0; one-cycle ic_valid.
// - ic_req and dc_req rise together -> data served first, then instruction; one valid pulse each, in order.
// - dc write 0x2040, wdata 0xA5..A5 -> mem_we=1, mem_wdata matches; dc_valid pulse; dc_rdata unchanged.
// - No mem_ack, TIMEOUT=4 -> abort after 4 BUSY cycles; ic_valid=1, ic_rdata=0, mem_err stays 1.
// - mem_ack while IDLE and on the timeout cycle -> first ignored; second completes normally, no error.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and memory signal bundle shared by the arbiter and its environment.
// The slave view is the arbiter; the master view drives requests and answers as memory.
interface mem_arbiter_if #(
    parameter int ADDRESS_SIZE = 32,
    parameter int LINE_SIZE    = 128
);
    logic                    ic_req;
    logic [ADDRESS_SIZE-1:0] ic_addr;
    logic                    ic_valid;
    logic [LINE_SIZE-1:0]    ic_rdata;

    logic                    dc_req;
    logic                    dc_we;
    logic [ADDRESS_SIZE-1:0] dc_addr;
    logic [LINE_SIZE-1:0]    dc_wdata;
    logic                    dc_valid;
    logic [LINE_SIZE-1:0]    dc_rdata;

    logic                    mem_req;
    logic                    mem_we;
    logic [ADDRESS_SIZE-1:0] mem_addr;
    logic [LINE_SIZE-1:0]    mem_wdata;
    logic                    mem_ack;
    logic [LINE_SIZE-1:0]    mem_rdata;
    logic                    mem_err;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
        output ic_valid, ic_rdata, dc_valid, dc_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_err
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
        input  ic_valid, ic_rdata, dc_valid, dc_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the instruction- and data-miss paths.
// Data has fixed priority; a watchdog aborts memory transactions that never acknowledge.
module mem_arbiter #(
    parameter int ADDRESS_SIZE = 32,
    parameter int LINE_SIZE    = 128,
    parameter int TIMEOUT      = 255
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int              WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    // IDLE: wait for a request | BUSY_I/BUSY_D: memory handshake | RESP: one-cycle valid
    typedef enum logic [1:0] { IDLE, BUSY_I, BUSY_D, RESP } state_t;

    state_t                  state_q, state_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_SIZE-1:0]    mem_wdata_q, mem_wdata_d;
    logic                    mem_err_q, mem_err_d;
    logic                    ic_valid_q, ic_valid_d;
    logic [LINE_SIZE-1:0]    ic_rdata_q, ic_rdata_d;
    logic                    dc_valid_q, dc_valid_d;
    logic [LINE_SIZE-1:0]    dc_rdata_q, dc_rdata_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wd_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_err_q   <= 1'b0;
            ic_valid_q  <= 1'b0;
            ic_rdata_q  <= '0;
            dc_valid_q  <= 1'b0;
            dc_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_err_q   <= mem_err_d;
            ic_valid_q  <= ic_valid_d;
            ic_rdata_q  <= ic_rdata_d;
            dc_valid_q  <= dc_valid_d;
            dc_rdata_q  <= dc_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_err_d   = mem_err_q;
        ic_valid_d  = 1'b0;
        ic_rdata_d  = ic_rdata_q;
        dc_valid_d  = 1'b0;
        dc_rdata_d  = dc_rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.dc_req) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dc_we;
                    mem_addr_d  = bus.dc_addr;
                    mem_wdata_d = bus.dc_wdata;
                    wd_d        = '0;
                end else if (bus.ic_req) begin
                    state_d     = BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.ic_addr;
                    mem_wdata_d = '0;
                    wd_d        = '0;
                end
            end

            BUSY_I, BUSY_D: begin
                wd_d = wd_q + 1'b1;
                // An acknowledge on the final watchdog cycle still completes normally.
                if (bus.mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        ic_valid_d = 1'b1;
                        ic_rdata_d = bus.mem_rdata;
                    end else begin
                        dc_valid_d = 1'b1;
                        if (!mem_we_q) begin
                            dc_rdata_d = bus.mem_rdata;
                        end
                    end
                end else if (wd_d == WD_LIMIT) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                    if (state_q == BUSY_I) begin
                        ic_valid_d = 1'b1;
                        ic_rdata_d = '0;
                    end else begin
                        dc_valid_d = 1'b1;
                        dc_rdata_d = '0;
                    end
                end
            end

            RESP: begin
                wd_d    = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_err   = mem_err_q;
    assign bus.ic_valid  = ic_valid_q;
    assign bus.ic_rdata  = ic_rdata_q;
    assign bus.dc_valid  = dc_valid_q;
    assign bus.dc_rdata  = dc_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model with per-cycle output compare,
// directed scenarios with literal expectations, then randomized requesters and memory.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int TO = 4;

    localparam logic [LW-1:0] R_I  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [LW-1:0] R_P  = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    localparam logic [LW-1:0] R_A5 = {16{8'hA5}};
    localparam logic [LW-1:0] R_6  = 128'h6666_0000_6666_0000_6666_0000_6666_0001;
    localparam logic [LW-1:0] R_7  = 128'h7777_1234_7777_1234_7777_1234_7777_1234;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDRESS_SIZE(AW), .LINE_SIZE(LW)) bus ();

    mem_arbiter #(.ADDRESS_SIZE(AW), .LINE_SIZE(LW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // One granted transaction, described by its grant cycle and its memory delay.
    typedef struct {
        bit            active;
        bit            is_d;
        bit            we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
        int            g;
        int            d;
        int            len;
        bit            to;
    } txn_t;

    txn_t          cur;
    int            cyc       = 0;
    int            idle_from = 0;
    logic [LW-1:0] st_ic_rdata = '0;
    logic [LW-1:0] st_dc_rdata = '0;
    logic [LW-1:0] st_wdata    = '0;
    logic [AW-1:0] st_addr     = '0;
    bit            st_we       = 1'b0;
    bit            st_err      = 1'b0;

    int            force_d     = 0;
    bit            force_rd_en = 1'b1;
    logic [LW-1:0] force_rd    = '0;
    bit            noise_en    = 1'b0;
    bit            idle_ack    = 1'b0;

    function automatic logic [LW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic bit m_busy();
        return cur.active && cyc >= cur.g + 1 && cyc <= cur.g + cur.len;
    endfunction

    function automatic bit m_resp();
        return cur.active && cyc == cur.g + cur.len + 1;
    endfunction

    task automatic model_clear();
        cur.active  = 1'b0;
        idle_from   = 0;
        st_ic_rdata = '0;
        st_dc_rdata = '0;
        st_wdata    = '0;
        st_addr     = '0;
        st_we       = 1'b0;
        st_err      = 1'b0;
    endtask

    // Called at the edge that ends cycle `cyc`: retire a finished response, then grant.
    task automatic model_step();
        int c;
        c = cyc;
        if (cur.active && c == cur.g + cur.len + 1) begin
            if (cur.to) st_err = 1'b1;
            if (cur.is_d) begin
                if (cur.to) st_dc_rdata = '0;
                else if (!cur.we) st_dc_rdata = cur.rdata;
            end else begin
                st_ic_rdata = cur.to ? '0 : cur.rdata;
            end
            cur.active = 1'b0;
            idle_from  = c + 1;
        end
        if (!cur.active && c >= idle_from && (bus.dc_req || bus.ic_req)) begin
            cur.active = 1'b1;
            cur.g      = c;
            cur.is_d   = bus.dc_req;
            cur.we     = bus.dc_req && bus.dc_we;
            cur.addr   = bus.dc_req ? bus.dc_addr : bus.ic_addr;
            cur.wdata  = bus.dc_wdata;
            if (force_d > 0) cur.d = force_d;
            else if ($urandom_range(0, 9) == 0) cur.d = 1000;
            else cur.d = $urandom_range(1, TO + 2);
            cur.to    = cur.d > TO;
            cur.len   = cur.to ? TO : cur.d;
            cur.rdata = force_rd_en ? force_rd : rand_line();
            st_addr   = cur.addr;
            st_we     = cur.we;
            st_wdata  = cur.wdata;
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (reset) model_step();
        else model_clear();
        cyc++;
    end

    initial forever begin
        @(negedge reset);
        model_clear();
    end

    task automatic compare_outputs();
        bit            busy;
        bit            resp;
        logic [LW-1:0] e_ic;
        logic [LW-1:0] e_dc;
        busy = m_busy();
        resp = m_resp();
        e_ic = (resp && !cur.is_d) ? (cur.to ? '0 : cur.rdata) : st_ic_rdata;
        e_dc = (resp && cur.is_d) ? (cur.to ? '0 : (cur.we ? st_dc_rdata : cur.rdata)) : st_dc_rdata;
        chk("mem_req", LW'(bus.mem_req), LW'(busy));
        chk("ic_valid", LW'(bus.ic_valid), LW'(resp && !cur.is_d));
        chk("dc_valid", LW'(bus.dc_valid), LW'(resp && cur.is_d));
        chk("ic_rdata", bus.ic_rdata, e_ic);
        chk("dc_rdata", bus.dc_rdata, e_dc);
        chk("mem_err", LW'(bus.mem_err), LW'(st_err || (resp && cur.to)));
        if (busy) begin
            chk("mem_addr", LW'(bus.mem_addr), LW'(st_addr));
            chk("mem_we", LW'(bus.mem_we), LW'(st_we));
            if (st_we) chk("mem_wdata", bus.mem_wdata, st_wdata);
        end
        if (!reset) begin
            chk("rst_mem_addr", LW'(bus.mem_addr), LW'(0));
            chk("rst_mem_wdata", bus.mem_wdata, LW'(0));
        end
    endtask

    initial forever begin
        @(negedge clk);
        compare_outputs();
    end

    // Memory side: acknowledge on the cycle the model chose, plus stray acks outside BUSY.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (cur.active && cyc == cur.g + cur.d) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = cur.rdata;
            end else if (!m_busy() && (idle_ack || (noise_en && $urandom_range(0, 3) == 0))) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rand_line();
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = rand_line();
            end
        end
    end

    task automatic wait_for(input int which, input int bound, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < bound) begin
            @(negedge clk);
            n++;
            case (which)
                0:       ok = bus.mem_req;
                1:       ok = bus.ic_valid;
                default: ok = bus.dc_valid;
            endcase
        end
    endtask

    initial begin
        int n;
        bit ok;
        int ord;
        bus.ic_req   = 1'b0;
        bus.ic_addr  = '0;
        bus.dc_req   = 1'b0;
        bus.dc_we    = 1'b0;
        bus.dc_addr  = '0;
        bus.dc_wdata = '0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mem_req", LW'(bus.mem_req), LW'(0));
        chk("reset_valids", LW'({bus.ic_valid, bus.dc_valid}), LW'(0));
        chk("reset_mem_err", LW'(bus.mem_err), LW'(0));
        chk("reset_ic_rdata", bus.ic_rdata, LW'(0));

        // Instruction read, memory answers on the third BUSY cycle.
        force_d  = 3;
        force_rd = R_I;
        bus.ic_addr = 32'h1000;
        bus.ic_req  = 1'b1;
        wait_for(0, 20, n, ok);
        chk("i_grant_seen", LW'(ok), LW'(1));
        chk("i_mem_addr", LW'(bus.mem_addr), LW'(32'h1000));
        chk("i_mem_we", LW'(bus.mem_we), LW'(0));
        wait_for(1, 20, n, ok);
        chk("i_valid_seen", LW'(ok), LW'(1));
        chk("i_latency", LW'(n), LW'(3));
        chk("i_rdata", bus.ic_rdata, R_I);
        bus.ic_req = 1'b0;
        @(negedge clk);
        chk("i_valid_single", LW'(bus.ic_valid), LW'(0));

        // Simultaneous requests: data first, then instruction.
        force_d  = 1;
        force_rd = R_P;
        bus.dc_addr = 32'h3000;
        bus.dc_we   = 1'b0;
        bus.ic_addr = 32'h4000;
        bus.dc_req  = 1'b1;
        bus.ic_req  = 1'b1;
        ord = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.dc_valid) begin ord = ord * 10 + 2; bus.dc_req = 1'b0; end
            if (bus.ic_valid) begin ord = ord * 10 + 1; bus.ic_req = 1'b0; end
        end
        chk("prio_order", LW'(ord), LW'(21));
        chk("prio_dc_rdata", bus.dc_rdata, R_P);
        chk("prio_ic_rdata", bus.ic_rdata, R_P);

        // Data write leaves dc_rdata alone.
        force_d = 2;
        bus.dc_addr  = 32'h2040;
        bus.dc_we    = 1'b1;
        bus.dc_wdata = R_A5;
        bus.dc_req   = 1'b1;
        wait_for(0, 20, n, ok);
        chk("w_grant_seen", LW'(ok), LW'(1));
        chk("w_mem_we", LW'(bus.mem_we), LW'(1));
        chk("w_mem_addr", LW'(bus.mem_addr), LW'(32'h2040));
        chk("w_mem_wdata", bus.mem_wdata, R_A5);
        wait_for(2, 20, n, ok);
        chk("w_valid_seen", LW'(ok), LW'(1));
        chk("w_dc_rdata_kept", bus.dc_rdata, R_P);
        bus.dc_req = 1'b0;
        bus.dc_we  = 1'b0;
        @(negedge clk);

        // Memory never answers: abort after TO BUSY cycles.
        force_d = 1000;
        bus.ic_addr = 32'h1040;
        bus.ic_req  = 1'b1;
        wait_for(0, 20, n, ok);
        chk("to_grant_seen", LW'(ok), LW'(1));
        wait_for(1, 20, n, ok);
        chk("to_valid_seen", LW'(ok), LW'(1));
        chk("to_busy_cycles", LW'(n), LW'(TO));
        chk("to_ic_rdata", bus.ic_rdata, LW'(0));
        chk("to_mem_err", LW'(bus.mem_err), LW'(1));
        bus.ic_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("to_err_sticky", LW'(bus.mem_err), LW'(1));

        // Asynchronous reset in the middle of a data transaction.
        force_d = 1000;
        bus.dc_addr = 32'h6000;
        bus.dc_req  = 1'b1;
        wait_for(0, 20, n, ok);
        chk("rst_grant_seen", LW'(ok), LW'(1));
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mem_req_drop", LW'(bus.mem_req), LW'(0));
        chk("rst_mem_err_clear", LW'(bus.mem_err), LW'(0));
        bus.dc_req = 1'b0;
        n = 0;
        repeat (3) begin @(negedge clk); if (bus.dc_valid) n++; end
        reset = 1'b1;
        repeat (6) begin @(negedge clk); if (bus.dc_valid) n++; end
        chk("rst_no_valid", LW'(n), LW'(0));
        force_d  = 1;
        force_rd = R_7;
        bus.dc_addr = 32'h6040;
        bus.dc_req  = 1'b1;
        wait_for(2, 20, n, ok);
        chk("rst_regrant_seen", LW'(ok), LW'(1));
        chk("rst_regrant_rdata", bus.dc_rdata, R_7);
        bus.dc_req = 1'b0;
        @(negedge clk);

        // Stray ack while idle, then an ack landing on the last watchdog cycle.
        idle_ack = 1'b1;
        repeat (2) @(negedge clk);
        idle_ack = 1'b0;
        chk("idle_ack_ignored", LW'({bus.mem_req, bus.ic_valid, bus.dc_valid}), LW'(0));
        force_d  = TO;
        force_rd = R_6;
        bus.dc_addr = 32'h5000;
        bus.dc_req  = 1'b1;
        wait_for(0, 20, n, ok);
        chk("late_grant_seen", LW'(ok), LW'(1));
        wait_for(2, 20, n, ok);
        chk("late_valid_seen", LW'(ok), LW'(1));
        chk("late_latency", LW'(n), LW'(TO));
        chk("late_dc_rdata", bus.dc_rdata, R_6);
        chk("late_no_err", LW'(bus.mem_err), LW'(0));
        bus.dc_req = 1'b0;
        @(negedge clk);

        // Randomized requesters and memory.
        force_d     = 0;
        force_rd_en = 1'b0;
        noise_en    = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (m_resp() && !cur.is_d) bus.ic_req = 1'b0;
            else if (!bus.ic_req && $urandom_range(0, 3) == 0) begin
                bus.ic_addr = $urandom() & ~32'hF;
                bus.ic_req  = 1'b1;
            end
            if (m_resp() && cur.is_d) bus.dc_req = 1'b0;
            else if (!bus.dc_req && $urandom_range(0, 4) == 0) begin
                bus.dc_addr  = $urandom() & ~32'hF;
                bus.dc_we    = ($urandom_range(0, 1) == 1);
                bus.dc_wdata = rand_line();
                bus.dc_req   = 1'b1;
            end
        end
        bus.ic_req = 1'b0;
        bus.dc_req = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
